clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Multi-channel programmable integer clock divider. Generalises the fixed divide-by-5.
//  Each channel has a run-time divisor and high-time, so odd and even ratios get a
//  programmable duty cycle. A matching one-cycle tick strobe is provided for use as a
//  clock enable.
//  Sits between the board oscillator domain and peripherals (UART, PWM, LED scan).
//  Fully posedge, single clock domain.
// PARAMETERS
//  NUM_CH   2    number of independent divider channels
//  CNT_W    8    counter/divisor width per channel (max ratio 2**CNT_W-1)
//  DEF_DIV  5    divisor loaded at reset, all channels
//  DEF_HI   2    high-time (cycles) loaded at reset, all channels
// PORTS
//  in_clk    in   1             sole clock; all logic on posedge
//  reset     in   1             synchronous, active-high
//  en        in   NUM_CH        per-channel run enable
//  div_i     in   NUM_CH*CNT_W  requested divisor, ch k at [k*CNT_W +: CNT_W]
//  hi_i      in   NUM_CH*CNT_W  requested high-time, same packing
//  load      in   NUM_CH        1-cycle strobe: capture div_i/hi_i for ch k
//  out_clk   out  NUM_CH        divided clock, registered, glitch-free
//  tick      out  NUM_CH        1-cycle strobe at start of each out_clk high phase
//  pend      out  NUM_CH        captured setting not yet applied
// BEHAVIOUR
//  - Reset (sync): cnt=0, out_clk=0, tick=0, pend=0, active div=DEF_DIV, hi=DEF_HI.
//  - Sanitising, applied on capture: div<2 -> 2; hi==0 -> 1; hi>=div -> div-1.
//    out_clk therefore always toggles.
//  - Running (en=1): period = div cycles; out_clk high for hi cycles, then low div-hi.
//  - Start from idle: en sampled 1 at edge E0.
//    out_clk=1 and tick=1 in the cycle after E0 (latency 1).
//  - tick is high exactly in the first cycle of each high phase.
//  - Idle (en=0): at next edge cnt=0, out_clk=0, tick=0. Held there.
//    A mid-period drop truncates the period; no glitch (output is registered).
//  - load: div_i/hi_i captured into shadow regs, pend=1 next cycle.
//    Running: shadow becomes active at period wrap (last low cycle -> first high cycle).
//    pend clears in the cycle the new period starts.
//    Idle: shadow applied at next edge; pend clears.
//  - load while pend=1: shadow overwritten (last write wins), single apply.
//  - load in the wrap cycle itself: the captured value is applied at the NEXT wrap,
//    never in the same edge. Old settings finish the period that is just starting.
//  - Channels independent; simultaneous loads/enables on several channels are legal.
//  - Reset mid-period overrides everything, including a pending load (discarded).
//  - Counter compare is unsigned CNT_W-bit; no overflow since cnt<=div-1<2**CNT_W.
// STRUCTURE
//  - Shared package clk_div_pkg:
//    CNT_W default, DEF_DIV/DEF_HI, and the sanitise function (div, hi) -> (div, hi).
//  - Sub-module clk_div_chan: one channel (counter, shadow/active regs, pend,
//    out/tick regs).
//  - Top generates NUM_CH instances and slices the packed buses.
// TESTING
//  1. Reset then en=1, defaults: out_clk 1,1,0,0,0 repeating; tick every 5th cycle;
//     first high 1 cycle after en.
//  2. load div=4 hi=2 mid-period (running, div=5): current 5-cycle period completes,
//     then 1,1,0,0; pend high until switch.
//  3. Sanitise: load div=1 hi=0 -> active 2/1 (out 1,0). load div=6 hi=9 -> 6/5.
//  4. en drop at cycle 2 of high phase: out_clk=0 next cycle, stays 0.
//     Re-enable restarts with a full hi phase plus tick.
//  5. Back-to-back loads (div=7 then div=3, before wrap): only 3 applied; pend single
//     clear. Load in the wrap cycle is deferred one period.
//  6. NUM_CH=2: ch0 div=3, ch1 div=8 loaded same cycle; reset asserted mid-run.
//     Both out_clk=0, pend=0, defaults restored next cycle.

Source files
------------

// File: rtl/clk_div_pkg.sv
//------------------------------------------------------------------------------
// Module   : clk_div_pkg
// Brief    : Shared defaults and divisor/high-time sanitising for clk_div_prog.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned DIV_DEF   = 5;
    localparam int unsigned HI_DEF    = 2;

    // Evaluated at 32 bits so any channel width can share these helpers.
    function automatic logic [31:0] sanitise_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

    function automatic logic [31:0] sanitise_hi(input logic [31:0] div,
                                                input logic [31:0] hi);
        logic [31:0] d;
        logic [31:0] h;
        d = sanitise_div(div);
        h = (hi == 32'd0) ? 32'd1 : hi;
        if (h >= d) begin
            h = d - 32'd1;
        end
        return h;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
//------------------------------------------------------------------------------
// Module   : clk_div_chan
// Brief    : One programmable divider channel with shadowed settings and tick.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DIV_DEF,
    parameter int unsigned DEF_HI  = HI_DEF
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] hi_i,
    input  logic             load,
    output logic             out_clk,
    output logic             tick,
    output logic             pend
);

    localparam logic [0:0]       S_IDLE = 1'b0;
    localparam logic [0:0]       S_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_run;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_hi_act;
    logic [CNT_W-1:0] r_div_sh;
    logic [CNT_W-1:0] r_hi_sh;
    logic             r_pend;
    logic             r_out;
    logic             r_tick;

    logic             w_wrap;
    logic             w_restart;
    logic             w_apply;
    logic [CNT_W-1:0] w_hi_eff;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        if (en) begin
            w_state_nxt = S_RUN;
        end
    end

    always_comb begin
        w_run = 1'b0;
        if (r_state == S_RUN) begin
            w_run = 1'b1;
        end
    end

    // A new period starts on the wrap edge or when leaving idle; pending
    // settings are only ever swapped in at such a boundary (or while idle).
    assign w_wrap    = w_run && (r_cnt == (r_div_act - c_ONE));
    assign w_restart = !w_run || w_wrap;
    assign w_apply   = r_pend && w_restart;
    assign w_hi_eff  = w_apply ? r_hi_sh : r_hi_act;

    always_comb begin
        w_cnt_nxt = '0;
        if (en && !w_restart) begin
            w_cnt_nxt = r_cnt + c_ONE;
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_out     <= 1'b0;
            r_tick    <= 1'b0;
            r_pend    <= 1'b0;
            r_div_act <= CNT_W'(DEF_DIV);
            r_hi_act  <= CNT_W'(DEF_HI);
            r_div_sh  <= CNT_W'(DEF_DIV);
            r_hi_sh   <= CNT_W'(DEF_HI);
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_out  <= en && (w_cnt_nxt < w_hi_eff);
            r_tick <= en && (w_cnt_nxt == '0);
            if (w_apply) begin
                r_div_act <= r_div_sh;
                r_hi_act  <= r_hi_sh;
            end
            if (load) begin
                r_div_sh <= CNT_W'(sanitise_div(32'(div_i)));
                r_hi_sh  <= CNT_W'(sanitise_hi(32'(div_i), 32'(hi_i)));
                r_pend   <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign out_clk = r_out;
    assign tick    = r_tick;
    assign pend    = r_pend;

endmodule

`default_nettype wire

// File: rtl/clk_div_prog.sv
//------------------------------------------------------------------------------
// Module   : clk_div_prog
// Brief    : Multi-channel programmable integer clock divider with tick strobes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DIV_DEF,
    parameter int unsigned DEF_HI  = HI_DEF
) (
    input  logic                    in_clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic [NUM_CH*CNT_W-1:0] hi_i,
    input  logic [NUM_CH-1:0]       load,
    output logic [NUM_CH-1:0]       out_clk,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pend
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV),
            .DEF_HI  (DEF_HI)
        ) u_chan (
            .in_clk  (in_clk),
            .reset   (reset),
            .en      (en[k]),
            .div_i   (div_i[k*CNT_W +: CNT_W]),
            .hi_i    (hi_i[k*CNT_W +: CNT_W]),
            .load    (load[k]),
            .out_clk (out_clk[k]),
            .tick    (tick[k]),
            .pend    (pend[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
//------------------------------------------------------------------------------
// Module   : tb_clk_div_prog
// Brief    : Scoreboard bench for clk_div_prog (two channels, 8-bit counters).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_prog;

    logic        in_clk = 1'b0;
    logic        reset  = 1'b1;
    logic [1:0]  en     = 2'b00;
    logic [1:0]  load   = 2'b00;
    logic [15:0] div_i  = 16'd0;
    logic [15:0] hi_i   = 16'd0;
    logic [1:0]  out_clk;
    logic [1:0]  tick;
    logic [1:0]  pend;

    int n_total = 0;
    int n_bad   = 0;

    int m_run[2], m_cnt[2], m_div[2], m_hi[2];
    int m_sd[2], m_sh[2], m_pend[2], m_out[2], m_tick[2];

    logic [5:0] sb[$];

    clk_div_prog u_dut (
        .in_clk  (in_clk),
        .reset   (reset),
        .en      (en),
        .div_i   (div_i),
        .hi_i    (hi_i),
        .load    (load),
        .out_clk (out_clk),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int san_div(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int san_hi(input int d, input int h);
        int dd;
        int hh;
        dd = san_div(d);
        hh = (h == 0) ? 1 : h;
        if (hh >= dd) hh = dd - 1;
        return hh;
    endfunction

    // Reference behaviour of one clock edge, computed from the current inputs.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                m_run[c] = 0; m_cnt[c] = 0; m_out[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
                m_div[c] = 5; m_hi[c] = 2; m_sd[c] = 5; m_sh[c] = 2;
            end else begin
                bit restart;
                restart = (m_run[c] == 0) || (m_cnt[c] == m_div[c] - 1);
                if (m_pend[c] != 0 && restart) begin
                    m_div[c]  = m_sd[c];
                    m_hi[c]   = m_sh[c];
                    m_pend[c] = 0;
                end
                if (load[c]) begin
                    m_sd[c]   = san_div(int'(div_i[c*8 +: 8]));
                    m_sh[c]   = san_hi(int'(div_i[c*8 +: 8]), int'(hi_i[c*8 +: 8]));
                    m_pend[c] = 1;
                end
                if (en[c]) begin
                    m_cnt[c]  = restart ? 0 : m_cnt[c] + 1;
                    m_run[c]  = 1;
                    m_out[c]  = (m_cnt[c] < m_hi[c]) ? 1 : 0;
                    m_tick[c] = (m_cnt[c] == 0) ? 1 : 0;
                end else begin
                    m_run[c] = 0; m_cnt[c] = 0; m_out[c] = 0; m_tick[c] = 0;
                end
            end
        end
    endtask

    task automatic step();
        logic [5:0] e;
        model_edge();
        sb.push_back({m_out[1][0], m_out[0][0], m_tick[1][0], m_tick[0][0],
                      m_pend[1][0], m_pend[0][0]});
        @(posedge in_clk);
        #1;
        e = sb.pop_front();
        chk("out",  32'(out_clk), 32'(e[5:4]));
        chk("tick", 32'(tick),    32'(e[3:2]));
        chk("pend", 32'(pend),    32'(e[1:0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cfg(input int c, input int d, input int h);
        div_i[c*8 +: 8] = 8'(d);
        hi_i[c*8 +: 8]  = 8'(h);
        load[c]         = 1'b1;
    endtask

    initial begin
        bit found;

        // Reset, then defaults on channel 0
        reset = 1'b1;
        run(2);
        chk("rst_out",  32'(out_clk), 32'd0);
        chk("rst_pend", 32'(pend),    32'd0);
        reset = 1'b0;
        en[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t1_out",  32'(out_clk[0]), ((k % 5) < 2) ? 32'd1 : 32'd0);
            chk("t1_tick", 32'(tick[0]),    ((k % 5) == 0) ? 32'd1 : 32'd0);
        end

        // Mid-period reprogramming to 4/2
        set_cfg(0, 4, 2);
        step();
        load = 2'b00;
        run(12);

        // Sanitising
        set_cfg(0, 1, 0);
        step();
        load = 2'b00;
        run(8);
        set_cfg(0, 6, 9);
        step();
        load = 2'b00;
        run(14);

        // Enable drop in the second high cycle, then restart
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tick[0]) found = 1'b1;
        end
        chk("t4_tickwait", 32'(found), 32'd1);
        step();
        en[0] = 1'b0;
        step();
        chk("t4_low", 32'(out_clk[0]), 32'd0);
        run(3);
        chk("t4_hold", 32'(out_clk[0]), 32'd0);
        en[0] = 1'b1;
        step();
        chk("t4_restart_out",  32'(out_clk[0]), 32'd1);
        chk("t4_restart_tick", 32'(tick[0]),    32'd1);
        run(8);

        // Back-to-back loads, then a load landing in the wrap cycle
        set_cfg(0, 7, 3);
        step();
        set_cfg(0, 3, 1);
        step();
        load = 2'b00;
        run(20);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_run[0] != 0 && m_cnt[0] == m_div[0] - 1) found = 1'b1;
            else step();
        end
        chk("t5_wrapwait", 32'(found), 32'd1);
        set_cfg(0, 4, 1);
        step();
        load = 2'b00;
        chk("t5_defer_pend", 32'(pend[0]), 32'd1);
        chk("t5_defer_tick", 32'(tick[0]), 32'd1);
        run(15);

        // Both channels, simultaneous loads, reset mid-run
        en = 2'b11;
        set_cfg(0, 3, 1);
        set_cfg(1, 8, 4);
        step();
        load = 2'b00;
        run(20);
        set_cfg(0, 9, 3);
        set_cfg(1, 2, 1);
        step();
        load  = 2'b00;
        reset = 1'b1;
        step();
        chk("t6_rst_out",  32'(out_clk), 32'd0);
        chk("t6_rst_pend", 32'(pend),    32'd0);
        reset = 1'b0;
        run(12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
